// File: rtl/g726_pkg.sv
// Shared G.726 constants, FSM state encoding and request payload for the UPA2 stage.
package g726_pkg;

    localparam int unsigned COEF_W = 16;
    localparam int unsigned UGA_W  = 17;
    localparam int unsigned CHW    = 5;

    // Gain-term constants for the second-pole update
    localparam logic [UGA_W-1:0]  UGA2A_PLUS   = 17'h04000;
    localparam logic [UGA_W-1:0]  UGA2A_MINUS  = 17'h1C000;

    // FA1 clamp thresholds and the clamped values (+/-32764 in 17-bit two's complement)
    localparam logic [COEF_W-1:0] FA1_POS_LIM  = 16'd8191;
    localparam logic [COEF_W-1:0] FA1_NEG_LIM  = 16'd57345;
    localparam logic [UGA_W-1:0]  FA1_POS_SAT  = 17'd32764;
    localparam logic [UGA_W-1:0]  FA1_NEG_SAT  = 17'h18004;

    // Sign-extension offsets for the arithmetic right shifts by 7
    localparam logic [COEF_W-1:0] UGA2_NEG_OFS = 16'd64512;
    localparam logic [COEF_W-1:0] ULA2_NEG_OFS = 16'd65024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CALC = 2'd2,
        ST_HOLD = 2'd3
    } upa2_state_e;

    typedef struct packed {
        logic [CHW-1:0]    ch;
        logic              pk0;
        logic              pk1;
        logic              pk2;
        logic              sigpk;
        logic [COEF_W-1:0] a1;
    } upa2_req_t;

endpackage

// File: rtl/upa2_stage_if.sv
// Request, A2T result and LIMC writeback bundle of the UPA2 stage.
interface upa2_stage_if;
    import g726_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CHW-1:0]    in_ch;
    logic              pk0;
    logic              pk1;
    logic              pk2;
    logic              sigpk;
    logic [COEF_W-1:0] a1;

    logic              a2t_valid;
    logic              a2t_ready;
    logic [CHW-1:0]    a2t_ch;
    logic [COEF_W-1:0] a2t;

    logic              wb_valid;
    logic [CHW-1:0]    wb_ch;
    logic [COEF_W-1:0] wb_a2p;

    modport master (
        output in_valid, in_ch, pk0, pk1, pk2, sigpk, a1, a2t_ready,
               wb_valid, wb_ch, wb_a2p,
        input  in_ready, a2t_valid, a2t_ch, a2t
    );

    modport slave (
        input  in_valid, in_ch, pk0, pk1, pk2, sigpk, a1, a2t_ready,
               wb_valid, wb_ch, wb_a2p,
        output in_ready, a2t_valid, a2t_ch, a2t
    );

endinterface

// File: rtl/upa2_calc.sv
// Combinational G.726 UPA2 datapath: unlimited second-pole update A2T from A2, A1 and sign bits.
module upa2_calc
    import g726_pkg::*;
(
    input  logic              pk0,
    input  logic              pk1,
    input  logic              pk2,
    input  logic              sigpk,
    input  logic [COEF_W-1:0] a1,
    input  logic [COEF_W-1:0] a2,
    output logic [COEF_W-1:0] a2t_c
);

    logic              pks1;
    logic              pks2;
    logic [UGA_W-1:0]  uga2a;
    logic [UGA_W-1:0]  fa1;
    logic [UGA_W-1:0]  fa;
    logic [UGA_W-1:0]  uga2b;
    logic [COEF_W-1:0] uga2_sh;
    logic [COEF_W-1:0] ula2_sh;
    logic [COEF_W-1:0] uga2;
    logic [COEF_W-1:0] ula2;

    // Gain term UGA2, leak term ULA2 and their modulo-2^16 sum with A2
    always_comb begin
        pks1 = pk0 ^ pk1;
        pks2 = pk0 ^ pk2;
        uga2a = pks2 ? UGA2A_MINUS : UGA2A_PLUS;

        // FA1 = 4*A1 clamped to +/-32764
        if (!a1[COEF_W-1]) begin
            fa1 = (a1 <= FA1_POS_LIM) ? {a1[COEF_W-2:0], 2'b00} : FA1_POS_SAT;
        end else begin
            fa1 = (a1 >= FA1_NEG_LIM) ? {a1[COEF_W-2:0], 2'b00} : FA1_NEG_SAT;
        end

        fa    = pks1 ? fa1 : UGA_W'(17'd0 - fa1);
        uga2b = UGA_W'(uga2a + fa);

        uga2_sh = COEF_W'(uga2b[UGA_W-1:7]);
        if (sigpk) begin
            uga2 = '0;
        end else if (uga2b[UGA_W-1]) begin
            uga2 = COEF_W'(uga2_sh + UGA2_NEG_OFS);
        end else begin
            uga2 = uga2_sh;
        end

        ula2_sh = COEF_W'(a2[COEF_W-1:7]);
        if (a2[COEF_W-1]) begin
            ula2 = COEF_W'(16'd0 - COEF_W'(ula2_sh + ULA2_NEG_OFS));
        end else begin
            ula2 = COEF_W'(16'd0 - ula2_sh);
        end

        a2t_c = COEF_W'(a2 + uga2 + ula2);
    end

endmodule

// File: rtl/upa2_stage.sv
// Time-multiplexed UPA2 stage: per-channel A2 store, one request in flight, A2T handed to LIMC.
module upa2_stage
    import g726_pkg::*;
#(
    parameter int unsigned NCH = 32
) (
    input  logic        clk,
    input  logic        reset,
    upa2_stage_if.slave bus,
    input  logic        scan_in0,
    input  logic        scan_enable,
    input  logic        test_mode,
    output logic        scan_out0
);

    upa2_state_e       state_q;
    upa2_state_e       state_d;
    upa2_req_t         req_q;

    logic [COEF_W-1:0] a2_mem [NCH];
    logic [COEF_W-1:0] a2_q;
    logic [COEF_W-1:0] a2_rd_c;
    logic [COEF_W-1:0] a2t_calc_c;

    logic              in_ready_q;
    logic              a2t_valid_q;
    logic [CHW-1:0]    a2t_ch_q;
    logic [COEF_W-1:0] a2t_q;

    logic              accept_c;
    logic              wb_in_range_c;
    logic              wb_hit_c;
    logic              load_req_c;
    logic              load_a2_c;
    logic              load_a2t_c;

    assign bus.in_ready  = in_ready_q;
    assign bus.a2t_valid = a2t_valid_q;
    assign bus.a2t_ch    = a2t_ch_q;
    assign bus.a2t       = a2t_q;

    assign accept_c      = bus.in_valid & in_ready_q;
    assign wb_in_range_c = ({1'b0, bus.wb_ch} < (CHW+1)'(NCH));
    assign wb_hit_c      = bus.wb_valid & wb_in_range_c & (bus.wb_ch == req_q.ch);

    // A2 fetch for the latched channel; a same-cycle writeback to it wins
    assign a2_rd_c = wb_hit_c ? bus.wb_a2p : a2_mem[req_q.ch];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_READ;
            ST_READ: state_d = ST_CALC;
            ST_CALC: state_d = ST_HOLD;
            ST_HOLD: if (bus.a2t_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state datapath load strobes
    always_comb begin
        load_req_c = 1'b0;
        load_a2_c  = 1'b0;
        load_a2t_c = 1'b0;
        case (state_q)
            ST_IDLE: load_req_c = accept_c;
            ST_READ: load_a2_c  = 1'b1;
            ST_CALC: load_a2t_c = 1'b1;
            default: ;
        endcase
    end

    upa2_calc u_calc (
        .pk0   (req_q.pk0),
        .pk1   (req_q.pk1),
        .pk2   (req_q.pk2),
        .sigpk (req_q.sigpk),
        .a1    (req_q.a1),
        .a2    (a2_q),
        .a2t_c (a2t_calc_c)
    );

    // Request latch, fetched A2, registered A2T and handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q       <= '0;
            a2_q        <= '0;
            a2t_q       <= '0;
            a2t_ch_q    <= '0;
            in_ready_q  <= 1'b0;
            a2t_valid_q <= 1'b0;
            scan_out0   <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == ST_IDLE);
            a2t_valid_q <= (state_d == ST_HOLD);
            scan_out0   <= scan_enable & test_mode & scan_in0;
            if (load_req_c) begin
                req_q <= '{ch: bus.in_ch, pk0: bus.pk0, pk1: bus.pk1, pk2: bus.pk2,
                           sigpk: bus.sigpk, a1: bus.a1};
            end
            if (load_a2_c) begin
                a2_q <= a2_rd_c;
            end
            if (load_a2t_c) begin
                a2t_q    <= a2t_calc_c;
                a2t_ch_q <= req_q.ch;
            end
        end
    end

    // A2 store: LIMC writeback in any state, out-of-range channels dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                a2_mem[i] <= '0;
            end
        end else if (bus.wb_valid && wb_in_range_c) begin
            a2_mem[bus.wb_ch] <= bus.wb_a2p;
        end
    end

endmodule

// File: tb/tb_upa2_stage.sv
// Bench for upa2_stage: directed vector table, multi-cycle corner sequences, randomized traffic.
module tb_upa2_stage;
    import g726_pkg::*;

    localparam int unsigned NCH    = 32;
    localparam int          N_RAND = 4000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scan_in0 = 1'b0;
    logic scan_enable = 1'b0;
    logic test_mode = 1'b0;
    logic scan_out0;

    upa2_stage_if bus ();

    upa2_stage #(.NCH(NCH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .scan_in0    (scan_in0),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_out0   (scan_out0)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] a2m [NCH];

    typedef struct {
        logic [4:0]  ch;
        logic        p0;
        logic        p1;
        logic        p2;
        logic        sig;
        logic [15:0] a1;
        logic        wb_en;
        logic [15:0] wb_val;
        logic [15:0] exp_a2t;
    } vec_t;

    vec_t vecs [9];

    // Abstract model: signed integer arithmetic, floor-division shifts
    function automatic logic [15:0] ref_a2t(input logic p0, input logic p1, input logic p2,
                                            input logic sig, input logic [15:0] a1,
                                            input logic [15:0] a2);
        int a1s, a2s, fa, ug_a, ug_b, ug, ul;
        a1s = int'($signed(a1));
        a2s = int'($signed(a2));
        fa = a1s * 4;
        if (fa > 32764) fa = 32764;
        else if (fa < -32764) fa = -32764;
        if (p0 == p1) fa = -fa;
        ug_a = (p0 != p2) ? -16384 : 16384;
        ug_b = ug_a + fa;
        ug   = sig ? 0 : (ug_b >>> 7);
        ul   = -(a2s >>> 7);
        return 16'(a2s + ug + ul);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_wb(input logic [4:0] ch, input logic [15:0] v);
        bus.wb_valid = 1'b1;
        bus.wb_ch    = ch;
        bus.wb_a2p   = v;
        a2m[ch]      = v;
        @(negedge clk);
        bus.wb_valid = 1'b0;
    endtask

    // Returns at the negedge of the READ cycle
    task automatic send_req(input logic [4:0] ch, input logic p0, input logic p1,
                            input logic p2, input logic sig, input logic [15:0] a1);
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_ch = ch;
        bus.pk0 = p0;
        bus.pk1 = p1;
        bus.pk2 = p2;
        bus.sigpk = sig;
        bus.a1 = a1;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input int stall, output logic [15:0] r, output logic [4:0] c,
                               output int lat);
        lat = 1;
        while (!bus.a2t_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check("result_valid", 32'(bus.a2t_valid), 32'd1);
        r = bus.a2t;
        c = bus.a2t_ch;
        if (bus.a2t_valid) begin
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                check("hold_valid", 32'(bus.a2t_valid), 32'd1);
                check("hold_a2t", 32'(bus.a2t), 32'(r));
                check("hold_ch", 32'(bus.a2t_ch), 32'(c));
                check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            end
            bus.a2t_ready = 1'b1;
            @(negedge clk);
            check("release_valid", 32'(bus.a2t_valid), 32'd0);
            check("release_in_ready", 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        logic [15:0] r;
        logic [4:0]  c;
        int          lat;
        logic [4:0]  ch;
        logic        p0, p1, p2, sig;
        logic [15:0] a1, e;
        int          phase, stall;
        logic [15:0] bnd [8];

        bnd = '{16'd0, 16'd8191, 16'd8192, 16'h7FFF, 16'h8000, 16'd57344, 16'd57345, 16'hFFFF};

        //          ch  p0 p1 p2 sig a1        wb  wb_val    exp
        vecs[0] = '{5'd3,  0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0080};
        vecs[1] = '{5'd3,  0, 0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000};
        vecs[2] = '{5'd5,  0, 0, 0, 1, 16'h0000, 1, 16'h3000, 16'h2FA0};
        vecs[3] = '{5'd5,  1, 1, 0, 0, 16'd8191, 0, 16'h0000, 16'h2E20};
        vecs[4] = '{5'd9,  0, 1, 0, 0, 16'd8192, 1, 16'h8000, 16'h827F};
        vecs[5] = '{5'd31, 1, 0, 1, 0, 16'hE001, 1, 16'hFFFF, 16'hFF80};
        vecs[6] = '{5'd0,  0, 0, 1, 0, 16'hE000, 1, 16'h7FFF, 16'h7F7F};
        vecs[7] = '{5'd1,  1, 1, 1, 0, 16'h8000, 0, 16'h0000, 16'h017F};
        vecs[8] = '{5'd3,  1, 1, 1, 0, 16'h7FFF, 0, 16'h0000, 16'hFF80};

        bus.in_valid = 1'b0;
        bus.in_ch = '0;
        bus.pk0 = 1'b0;
        bus.pk1 = 1'b0;
        bus.pk2 = 1'b0;
        bus.sigpk = 1'b0;
        bus.a1 = '0;
        bus.a2t_ready = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_ch = '0;
        bus.wb_a2p = '0;
        for (int i = 0; i < int'(NCH); i++) a2m[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_a2t_valid", 32'(bus.a2t_valid), 32'd0);
        check("rst_a2t", 32'(bus.a2t), 32'd0);
        check("rst_a2t_ch", 32'(bus.a2t_ch), 32'd0);
        check("rst_scan_out0", 32'(scan_out0), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wb_en) pulse_wb(vecs[i].ch, vecs[i].wb_val);
            bus.a2t_ready = 1'b1;
            send_req(vecs[i].ch, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].sig, vecs[i].a1);
            wait_result(0, r, c, lat);
            check($sformatf("vec%0d_a2t", i), 32'(r), 32'(vecs[i].exp_a2t));
            check($sformatf("vec%0d_ch", i), 32'(c), 32'(vecs[i].ch));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_model", i), 32'(r),
                  32'(ref_a2t(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].sig, vecs[i].a1,
                              a2m[vecs[i].ch])));
        end

        // Result held stable under 10 cycles of backpressure
        bus.a2t_ready = 1'b0;
        send_req(5'd5, 0, 0, 0, 1, 16'h0000);
        wait_result(10, r, c, lat);
        check("stall_a2t", 32'(r), 32'h2FA0);
        check("stall_ch", 32'(c), 32'd5);

        // Writeback in the READ cycle of the same channel is bypassed into the result
        pulse_wb(5'd7, 16'h1234);
        bus.a2t_ready = 1'b1;
        send_req(5'd7, 0, 0, 0, 1, 16'h0000);
        pulse_wb(5'd7, 16'h4000);
        wait_result(0, r, c, lat);
        check("bypass_a2t", 32'(r), 32'h3F80);
        check("bypass_ch", 32'(c), 32'd7);
        send_req(5'd7, 0, 0, 0, 1, 16'h0000);
        wait_result(0, r, c, lat);
        check("bypass_stored_a2t", 32'(r), 32'h3F80);

        // Reset during CALC aborts the request and clears the store
        send_req(5'd5, 0, 0, 0, 1, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_a2t_valid", 32'(bus.a2t_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_a2t", 32'(bus.a2t), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("midrst_hold_valid", 32'(bus.a2t_valid), 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < int'(NCH); i++) a2m[i] = '0;
        repeat (2) @(negedge clk);
        check("midrst_rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_rel_valid", 32'(bus.a2t_valid), 32'd0);
        send_req(5'd5, 0, 0, 0, 1, 16'h0000);
        wait_result(0, r, c, lat);
        check("midrst_cleared_ch5", 32'(r), 32'd0);
        send_req(5'd7, 0, 0, 0, 1, 16'h0000);
        wait_result(0, r, c, lat);
        check("midrst_cleared_ch7", 32'(r), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < N_RAND; n++) begin
            ch  = 5'($urandom_range(0, NCH - 1));
            p0  = 1'($urandom_range(0, 1));
            p1  = 1'($urandom_range(0, 1));
            p2  = 1'($urandom_range(0, 1));
            sig = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) a1 = bnd[$urandom_range(0, 7)];
            else a1 = 16'($urandom);
            phase = int'($urandom_range(0, 3));
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            if (phase == 1) pulse_wb(5'($urandom_range(0, NCH - 1)), 16'($urandom));
            bus.a2t_ready = (stall == 0);
            send_req(ch, p0, p1, p2, sig, a1);
            if (phase == 2) pulse_wb(ch, 16'($urandom));
            else if (phase == 3) pulse_wb(5'($urandom_range(0, NCH - 1)), 16'($urandom));
            e = ref_a2t(p0, p1, p2, sig, a1, a2m[ch]);
            wait_result(stall, r, c, lat);
            check($sformatf("rand%0d_a2t", n), 32'(r), 32'(e));
            check($sformatf("rand%0d_ch", n), 32'(c), 32'(ch));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
